// File: rtl/hart_puls_gen.sv
// Heartbeat pulse generator: turns a BPM request into a periodic pulse train
// timed on the slowClk tick enable, with an iterative period divider.
module hart_puls_gen #(
  parameter int TICK_HZ     = 1000,
  parameter int PULSE_TICKS = 50,
  parameter int MIN_BPM     = 30,
  parameter int MAX_BPM     = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slowClk,
  input  logic        enable,
  input  logic [7:0]  bpm,
  output logic        hartslag,
  output logic        beat,
  output logic [15:0] period,
  output logic        busy
);

  localparam logic [15:0] DIVIDEND = 16'(TICK_HZ * 60);
  localparam logic [15:0] PT       = 16'(PULSE_TICKS);

  typedef enum logic [1:0] {IDLE, CALC, RUN} state_t;
  state_t state, state_nx;

  logic [7:0]  bpm_l;
  logic [7:0]  rem;
  logic [15:0] quo;
  logic [3:0]  step;
  logic [15:0] cnt;

  function automatic logic [7:0] clamp(input logic [7:0] b);
    if (b == 8'd0)                 return 8'd0;
    else if (b < 8'(MIN_BPM))      return 8'(MIN_BPM);
    else if (b > 8'(MAX_BPM))      return 8'(MAX_BPM);
    else                           return b;
  endfunction

  logic [7:0] bpm_c;
  logic       stop, last_tick, div_done, ge;
  logic [8:0] trial;
  logic [7:0] rem_nx;

  always_comb begin
    bpm_c     = clamp(bpm);
    stop      = !enable || (bpm_c == 8'd0);
    last_tick = slowClk && (cnt == period - 16'd1);
    div_done  = (step == 4'd15);
    // quo shifts dividend bits out the top and quotient bits in the bottom
    trial     = {rem, quo[15]};
    ge        = (trial >= {1'b0, bpm_l});
    rem_nx    = ge ? 8'(trial - {1'b0, bpm_l}) : trial[7:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!stop) state_nx = CALC;
      CALC: if (stop) state_nx = IDLE;
            else if (div_done) state_nx = RUN;
      RUN:  if (stop) state_nx = IDLE;
            else if (last_tick) state_nx = CALC;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CALC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bpm_l    <= '0;
      rem      <= '0;
      quo      <= '0;
      step     <= '0;
      cnt      <= '0;
      period   <= '0;
      hartslag <= 1'b0;
      beat     <= 1'b0;
    end else begin
      state <= state_nx;
      beat  <= 1'b0;

      // bpm is only re-sampled when a divide starts, i.e. at beat boundaries
      if (state_nx == CALC && state != CALC) begin
        bpm_l <= bpm_c;
        quo   <= DIVIDEND;
        rem   <= '0;
        step  <= '0;
      end else if (state == CALC) begin
        quo  <= {quo[14:0], ge};
        rem  <= rem_nx;
        step <= step + 4'd1;
      end

      if (state == CALC && state_nx == RUN) begin
        period   <= {quo[14:0], ge};
        cnt      <= '0;
        hartslag <= 1'b1;
        beat     <= 1'b1;
      end else if (state == RUN && state_nx == RUN) begin
        if (slowClk) begin
          cnt      <= cnt + 16'd1;
          hartslag <= (cnt + 16'd1) < PT;
        end
      end else begin
        hartslag <= 1'b0;
      end
    end
  end

endmodule
